// File: rtl/tone_pkg.sv
// Shared types and constants for the speaker tone generator.
// Latency/backpressure: none (package only). The optional timed-beep feature is enabled by TONE_DURATION_EN.
package tone_pkg;

    localparam int unsigned CLK_HZ_DEF = 50_000_000;
    localparam int unsigned DIV_CYCLES = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_PLAY   = 2'd2
`ifdef TONE_DURATION_EN
        ,
        ST_HOLD   = 2'd3
`endif
    } tone_state_t;

    // A zero quotient means the tone is faster than clk/2; toggle every cycle instead.
    function automatic logic [31:0] clamp_half(input logic [31:0] q);
        return (q == 32'd0) ? 32'd1 : q;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// 32-bit unsigned restoring divider (33-bit divisor), one quotient bit per cycle.
// Latency: valid pulses DIV_CYCLES+1 edges after the start edge. No backpressure; start while running restarts.
module seq_divider
    import tone_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [32:0] divisor,
    output logic [31:0] quotient,
    output logic        valid
);

    logic [32:0] rem_q;
    logic [31:0] quo_q;
    logic [32:0] dvs_q;
    logic [5:0]  cnt_q;
    logic        run_q;
    logic        valid_q;

    logic [33:0] rem_sh;
    logic [33:0] rem_diff;
    logic        ge;

    // Dividend bits are shifted out of the top of quo_q while quotient bits enter at the bottom.
    assign rem_sh   = {rem_q, quo_q[31]};
    assign ge       = (rem_sh >= {1'b0, dvs_q});
    assign rem_diff = rem_sh - {1'b0, dvs_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (start) begin
                rem_q <= '0;
                quo_q <= dividend;
                dvs_q <= divisor;
                cnt_q <= 6'(DIV_CYCLES);
                run_q <= 1'b1;
            end else if (run_q) begin
                rem_q <= ge ? rem_diff[32:0] : rem_sh[32:0];
                quo_q <= {quo_q[30:0], ge};
                cnt_q <= cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    run_q   <= 1'b0;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo_q;
    assign valid    = valid_q;

endmodule

// File: rtl/tone_gen.sv
// Frequency (Hz) to 50 % duty speaker square wave; optional timed beep with TONE_DURATION_EN.
// Latency: DIVIDE entered on the change edge, PLAY 33 edges later; zero silences in 1 edge. No backpressure.
module tone_gen
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ = CLK_HZ_DEF,
    parameter int unsigned DUR_MS = 250
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] desiredFrequency,
    output logic        spkr,
    output logic        busy
`ifdef TONE_DURATION_EN
    ,
    output logic        done
`endif
);

    tone_state_t state;
    logic [31:0] freq_q;
    logic [31:0] half_q;
    logic [31:0] half_cnt;

    logic        change;
    logic        div_start;
    logic        div_valid;
    logic [31:0] div_quotient;
    logic [31:0] half_new;

    assign change    = (desiredFrequency != freq_q);
    assign div_start = change && (desiredFrequency != 32'd0);
    assign half_new  = clamp_half(div_quotient);
    assign busy      = (state == ST_DIVIDE);

    // Divider samples the raw input so it starts on the same edge that freq_q updates.
    seq_divider u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start),
        .dividend (32'(CLK_HZ)),
        .divisor  ({desiredFrequency, 1'b0}),
        .quotient (div_quotient),
        .valid    (div_valid)
    );

`ifdef TONE_DURATION_EN
    localparam longint unsigned DUR_CYCLES = (longint'(DUR_MS) * longint'(CLK_HZ)) / 1000;
    localparam logic [31:0]     DUR_LOAD   = (DUR_CYCLES == 0) ? 32'd0 : 32'(DUR_CYCLES - 1);
    logic [31:0] dur_cnt;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            freq_q   <= '0;
            spkr     <= 1'b0;
            half_q   <= '0;
            half_cnt <= '0;
`ifdef TONE_DURATION_EN
            dur_cnt  <= '0;
            done     <= 1'b0;
`endif
        end else begin
            freq_q <= desiredFrequency;
`ifdef TONE_DURATION_EN
            done   <= 1'b0;
`endif
            if (change) begin
                spkr  <= 1'b0;
                state <= (desiredFrequency == 32'd0) ? ST_IDLE : ST_DIVIDE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        spkr <= 1'b0;
                    end
                    ST_DIVIDE: begin
                        if (div_valid) begin
                            state    <= ST_PLAY;
                            spkr     <= 1'b1;
                            half_q   <= half_new;
                            half_cnt <= half_new - 32'd1;
`ifdef TONE_DURATION_EN
                            dur_cnt  <= DUR_LOAD;
`endif
                        end
                    end
                    ST_PLAY: begin
`ifdef TONE_DURATION_EN
                        if (dur_cnt == 32'd0) begin
                            state <= ST_HOLD;
                            spkr  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            dur_cnt <= dur_cnt - 32'd1;
                            if (half_cnt == 32'd0) begin
                                spkr     <= ~spkr;
                                half_cnt <= half_q - 32'd1;
                            end else begin
                                half_cnt <= half_cnt - 32'd1;
                            end
                        end
`else
                        if (half_cnt == 32'd0) begin
                            spkr     <= ~spkr;
                            half_cnt <= half_q - 32'd1;
                        end else begin
                            half_cnt <= half_cnt - 32'd1;
                        end
`endif
                    end
`ifdef TONE_DURATION_EN
                    ST_HOLD: begin
                        spkr <= 1'b0;
                    end
`endif
                    default: begin
                        state <= ST_IDLE;
                        spkr  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
